dsp_div: RTL and testbench
==========================

Name: dsp_div

Overview:
- Multi-cycle 32-bit integer divider for the sail-core execute stage.
- Covers RV32M DIV, DIVU, REM and REMU.
- Counterpart of the DSP adder: each trial subtraction runs on an SB_MAC16 configured as a bypassed 32-bit subtractor (ADDSUBTOP/ADDSUBBOT=1).
- Restoring algorithm, one quotient bit per cycle, start/busy/done handshake toward the pipeline stall logic.

Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- is_signed  in  1  1=DIV/REM semantics, 0=DIVU/REMU.
- dividend  in  32  numerator.
- divisor  in  32  denominator.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- quotient  out  32  result quotient.
- remainder  out  32  result remainder.

Behaviour:
- One clock. Reset is synchronous and active-low: on clk rising edge with reset_n=0, state=IDLE and busy, done, quotient, remainder, counter and all internal registers go to 0.
- Reset mid-operation aborts with no done pulse; the next accept starts fresh.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, start=1 (accept cycle):
  - Latch is_signed and the operand signs.
  - Latch |dividend| into the shift register and |divisor| into the divisor register; absolute values apply only when is_signed=1.
  - Clear the 33-bit partial remainder; counter=0.
  - If divisor==0: latch quotient=32'hFFFF_FFFF, remainder=dividend, go to DONE.
  - Else if is_signed, dividend==32'h8000_0000 and divisor==32'hFFFF_FFFF: latch quotient=32'h8000_0000, remainder=0, go to DONE.
  - Otherwise go to CALC.
- CALC, one iteration per cycle, exactly 32 cycles:
  - shifted = {prem[31:0], dvd[31]}; trial = shifted[31:0] - divisor via dsp_sub.
  - Take trial when shifted[32]=1 or borrow=0: prem={1'b0,trial}, quotient bit=1. Else prem=shifted, bit=0.
  - dvd shifts left with the new bit entering at bit 0; counter increments.
  - Leave for FIXUP after the iteration where counter==31.
- FIXUP, 1 cycle:
  - quotient = dvd, negated (two's complement) if is_signed and the operand signs differ.
  - remainder = prem[31:0], negated if is_signed and the dividend was negative.
  - Go to DONE.
- DONE, 1 cycle: done=1, busy=0, then IDLE. start in DONE is ignored.
- busy=1 throughout CALC and FIXUP.
- Latency from the accept edge:
  - Normal case: done is high in the 34th cycle after the accept cycle (32 CALC + 1 FIXUP + DONE).
  - Special case: done is high in the cycle immediately after the accept.
- start while busy=1 or done=1 is ignored, with no queuing. Operand inputs are don't-care after accept.
- quotient and remainder hold their last values until the next result is latched; they are not cleared on accept.
- Arithmetic wraps at 32 bits. Negating 32'h8000_0000 yields itself, and the unsigned core handles that correctly.

Decomposition:
- Package sail_div_pkg:
  - state enum {IDLE, CALC, FIXUP, DONE};
  - DIV_ITER=32;
  - constants DIV0_QUOT=32'hFFFF_FFFF and OVF_QUOT=32'h8000_0000.
- Sub-module dsp_sub, purely combinational:
  - ports: a[31:0], b[31:0], diff[31:0], borrow;
  - one SB_MAC16 in bypassed 32-bit unsigned subtract mode, all registers bypassed, CE=0;
  - borrow derives from the top-half carry output (CO inverted);
  - instantiated once in dsp_div.
- Verification runs against a behavioural dsp_sub model.

Test Plan:
- Unsigned: start, is_signed=0, dividend=100, divisor=7 -> done 34 cycles later, quotient=14, remainder=2; busy high for exactly 33 cycles.
- Signed: is_signed=1, dividend=-7 (32'hFFFF_FFF9), divisor=2 -> quotient=32'hFFFF_FFFD (-3), remainder=32'hFFFF_FFFF (-1). Repeat with dividend=7, divisor=-2 -> quotient=-3, remainder=1.
- Divide by zero: dividend=32'h1234_5678, divisor=0 (both is_signed values) -> done next cycle, quotient=32'hFFFF_FFFF, remainder=32'h1234_5678.
- Overflow: is_signed=1, dividend=32'h8000_0000, divisor=32'hFFFF_FFFF -> done next cycle, quotient=32'h8000_0000, remainder=0. Same operands with is_signed=0 -> 34-cycle path, quotient=0, remainder=32'h8000_0000.
- Handshake: raise start again during CALC with new operands -> ignored, first result unchanged. Back-to-back start in the cycle after done -> accepted.
- Reset mid-op: drop reset_n for 1 cycle at CALC iteration 10 -> busy=0, done=0, outputs=0, no done pulse. A following DIVU 32'hFFFF_FFFF/3 -> quotient=32'h5555_5555, remainder=0.

Source files
------------

// File: rtl/sail_div_pkg.sv
// sail_div_pkg: shared types and constants for the sail-core integer divider.
//   div_state_e : divider control states
//   DIV_ITER    : restoring iterations per operation (one quotient bit each)
//   DIV0_QUOT   : quotient returned for division by zero
//   OVF_QUOT    : quotient returned for signed overflow (INT_MIN / -1)
//   OVF_DSR     : the -1 divisor that triggers signed overflow
//   cond_neg    : two's-complement negate when en=1, pass-through otherwise
package sail_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  localparam int          DIV_ITER  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;
  localparam logic [31:0] OVF_DSR   = 32'hFFFF_FFFF;

  // Negating 32'h8000_0000 wraps back to itself; the unsigned core relies on that.
  function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic en);
    logic [31:0] res;
    if (en) begin
      res = ~x + 32'd1;
    end else begin
      res = x;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsp_sub.sv
// dsp_sub: purely combinational 32-bit unsigned subtractor, diff = a - b.
// On iCE40 targets (SAIL_ICE40 defined) it is one SB_MAC16 with every register
// bypassed, CE=0, both adder halves in subtract mode and the bottom-half carry
// cascaded into the top half. Otherwise an equivalent behavioural form is used.
//   a      in  32  minuend
//   b      in  32  subtrahend
//   diff   out 32  a - b, wrapped to 32 bits
//   borrow out 1   1 when b > a (inverse of the top-half carry out)
module dsp_sub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        borrow
);

`ifdef SAIL_ICE40
  logic co_s;
  logic accumco_s;
  logic signextout_s;

  // Adder upper operands come from C:D (minuend), lower from A:B (subtrahend).
  SB_MAC16 #(
    .NEG_TRIGGER              (1'b0),
    .C_REG                    (1'b0),
    .A_REG                    (1'b0),
    .B_REG                    (1'b0),
    .D_REG                    (1'b0),
    .TOP_8x8_MULT_REG         (1'b0),
    .BOT_8x8_MULT_REG         (1'b0),
    .PIPELINE_16x16_MULT_REG1 (1'b0),
    .PIPELINE_16x16_MULT_REG2 (1'b0),
    .TOPOUTPUT_SELECT         (2'b00),
    .TOPADDSUB_LOWERINPUT     (2'b00),
    .TOPADDSUB_UPPERINPUT     (1'b1),
    .TOPADDSUB_CARRYSELECT    (2'b10),
    .BOTOUTPUT_SELECT         (2'b00),
    .BOTADDSUB_LOWERINPUT     (2'b00),
    .BOTADDSUB_UPPERINPUT     (1'b1),
    .BOTADDSUB_CARRYSELECT    (2'b00),
    .MODE_8x8                 (1'b0),
    .A_SIGNED                 (1'b0),
    .B_SIGNED                 (1'b0)
  ) u_mac (
    .CLK        (1'b0),
    .CE         (1'b0),
    .C          (a[31:16]),
    .A          (b[31:16]),
    .B          (b[15:0]),
    .D          (a[15:0]),
    .AHOLD      (1'b0),
    .BHOLD      (1'b0),
    .CHOLD      (1'b0),
    .DHOLD      (1'b0),
    .IRSTTOP    (1'b0),
    .IRSTBOT    (1'b0),
    .ORSTTOP    (1'b0),
    .ORSTBOT    (1'b0),
    .OLOADTOP   (1'b0),
    .OLOADBOT   (1'b0),
    .ADDSUBTOP  (1'b1),
    .ADDSUBBOT  (1'b1),
    .OHOLDTOP   (1'b0),
    .OHOLDBOT   (1'b0),
    .CI         (1'b0),
    .ACCUMCI    (1'b0),
    .SIGNEXTIN  (1'b0),
    .O          (diff),
    .CO         (co_s),
    .ACCUMCO    (accumco_s),
    .SIGNEXTOUT (signextout_s)
  );

  assign borrow = ~co_s;
`else
  logic [32:0] sum_s;

  // a + ~b + 1: the carry out is the MAC's CO, so no borrow when it is 1.
  assign sum_s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
  assign diff   = sum_s[31:0];
  assign borrow = ~sum_s[32];
`endif

endmodule

// File: rtl/dsp_div.sv
// dsp_div: multi-cycle 32-bit restoring divider (RV32M DIV/DIVU/REM/REMU).
// Signed operations run on magnitudes and are sign-corrected in FIXUP.
// Division by zero and INT_MIN / -1 complete straight from the accept cycle.
//   clk       in  1   system clock
//   reset_n   in  1   synchronous active-low reset
//   start     in  1   request, accepted only in IDLE
//   is_signed in  1   1 = DIV/REM, 0 = DIVU/REMU
//   dividend  in  32  numerator
//   divisor   in  32  denominator
//   busy      out 1   high through CALC and FIXUP
//   done      out 1   one-cycle pulse, results valid from this cycle
//   quotient  out 32  result quotient (held until the next result)
//   remainder out 32  result remainder (held until the next result)
module dsp_div
  import sail_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e  state_r;
  div_state_e  next_state_s;

  logic        sgn_r;
  logic        dvd_neg_r;
  logic        dsr_neg_r;
  logic [31:0] dvd_r;
  logic [31:0] dsr_r;
  // Partial remainder. Its bit 32 is always zero after a step (a set bit 32
  // forces the subtraction), so only the low 32 bits are stored; the transient
  // 33rd bit lives in shifted_s.
  logic [31:0] prem_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0] quot_r;
  logic [31:0] rem_r;
  logic        busy_r;
  logic        done_r;

  logic [32:0] shifted_s;
  logic [31:0] trial_s;
  logic        borrow_s;
  logic        take_s;
  logic        div0_s;
  logic        ovf_s;
  logic        dvd_neg_s;
  logic        dsr_neg_s;

  assign dvd_neg_s = is_signed & dividend[31];
  assign dsr_neg_s = is_signed & divisor[31];
  assign div0_s    = (divisor == 32'h0000_0000);
  assign ovf_s     = is_signed & (dividend == OVF_QUOT) & (divisor == OVF_DSR);

  assign shifted_s = {prem_r, dvd_r[31]};

  dsp_sub u_sub (
    .a      (shifted_s[31:0]),
    .b      (dsr_r),
    .diff   (trial_s),
    .borrow (borrow_s)
  );

  // A set bit 32 means shifted exceeds any 32-bit divisor, whatever the borrow says.
  assign take_s = shifted_s[32] | ~borrow_s;

  // Next-state decode for the divider control FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (div0_s || ovf_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = CALC;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_LAST) begin
          next_state_s = FIXUP;
        end else begin
          next_state_s = CALC;
        end
      end
      FIXUP:   next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register plus busy/done flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == CALC) || (next_state_s == FIXUP);
      done_r  <= (next_state_s == DONE);
    end
  end

  // Datapath: operand capture, restoring iterations and sign fixup.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sgn_r     <= 1'b0;
      dvd_neg_r <= 1'b0;
      dsr_neg_r <= 1'b0;
      dvd_r     <= 32'h0000_0000;
      dsr_r     <= 32'h0000_0000;
      prem_r    <= 32'h0000_0000;
      cnt_r     <= {CNT_W{1'b0}};
      quot_r    <= 32'h0000_0000;
      rem_r     <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            sgn_r     <= is_signed;
            dvd_neg_r <= dvd_neg_s;
            dsr_neg_r <= dsr_neg_s;
            dvd_r     <= cond_neg(dividend, dvd_neg_s);
            dsr_r     <= cond_neg(divisor, dsr_neg_s);
            prem_r    <= 32'h0000_0000;
            cnt_r     <= {CNT_W{1'b0}};
            if (div0_s) begin
              quot_r <= DIV0_QUOT;
              rem_r  <= dividend;
            end else if (ovf_s) begin
              quot_r <= OVF_QUOT;
              rem_r  <= 32'h0000_0000;
            end else begin
              quot_r <= quot_r;
              rem_r  <= rem_r;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        CALC: begin
          // Quotient bits fill dvd_r from the bottom as dividend bits leave the top.
          if (take_s) begin
            prem_r <= trial_s;
          end else begin
            prem_r <= shifted_s[31:0];
          end
          dvd_r <= {dvd_r[30:0], take_s};
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIXUP: begin
          quot_r <= cond_neg(dvd_r, sgn_r & (dvd_neg_r ^ dsr_neg_r));
          rem_r  <= cond_neg(prem_r, sgn_r & dvd_neg_r);
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quot_r;
  assign remainder = rem_r;

endmodule

// File: tb/tb_dsp_div.sv
// tb_dsp_div: self-checking bench for dsp_div. Directed vectors from a table,
// hand-written handshake/reset sequences and randomized operations checked
// against an arithmetic reference model.
module tb_dsp_div;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dsp_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: RV32M results from plain arithmetic; latency 1 for the early-out cases.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 1;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
      lat = 34;
    end else begin
      q = a / b; r = a % b; lat = 34;
    end
  endfunction

  // Issue one operation and wait (bounded) for done. Returns at the negedge where done is seen.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    is_signed = 1'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
    lat  = -1;
    bcnt = 0;
    for (int c = 1; c <= 100; c++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    q = quotient;
    r = remainder;
  endtask

  initial begin
    vec_t        vecs[10];
    logic [31:0] q, r, eq, er;
    int          lat, bcnt, elat, ndone;
    logic        s;
    logic [31:0] a, b;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  34};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          34};
    vecs[3] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1};
    vecs[4] = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1};
    vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  34};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  32'd0,          34};
    vecs[8] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          34};
    vecs[9] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          34};

    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    chkint("reset_busy", int'(busy), 0);
    chkint("reset_done", int'(done), 0);
    chk32("reset_quot", quotient, 32'd0);
    chk32("reset_rem", remainder, 32'd0);
    reset_n = 1'b1;

    // Directed table; consecutive entries also exercise back-to-back accepts.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, q, r, lat, bcnt);
      chk32($sformatf("vec%0d_quot", i), q, vecs[i].q);
      chk32($sformatf("vec%0d_rem", i), r, vecs[i].r);
      chkint($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chkint($sformatf("vec%0d_busy", i), bcnt, (vecs[i].lat == 34) ? 33 : 0);
    end

    // Start held high during CALC and through DONE with new operands: ignored.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    dividend = 32'd999; divisor = 32'd1;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    chkint("hold_start_lat", lat, 34);
    chk32("hold_start_quot", quotient, 32'd14);
    chk32("hold_start_rem", remainder, 32'd2);
    @(negedge clk);
    chkint("start_in_done_ignored", int'(busy), 0);
    start = 1'b0;
    @(negedge clk);
    chkint("idle_after_release", int'(busy), 0);

    // Reset in the middle of CALC aborts without a done pulse.
    start = 1'b1; is_signed = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chkint("midreset_busy", int'(busy), 0);
    chkint("midreset_done", int'(done), 0);
    chk32("midreset_quot", quotient, 32'd0);
    chk32("midreset_rem", remainder, 32'd0);
    ndone = 0;
    for (int c = 0; c < 50; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chkint("midreset_no_done", ndone, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd3, q, r, lat, bcnt);
    chk32("post_reset_quot", q, 32'h5555_5555);
    chk32("post_reset_rem", r, 32'd0);
    chkint("post_reset_lat", lat, 34);

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 15));
        4: b = -32'($urandom_range(1, 15));
        default: a = a;
      endcase
      ref_div(s, a, b, eq, er, elat);
      run_op(s, a, b, q, r, lat, bcnt);
      chk32($sformatf("rnd%0d_quot s=%0d a=%h b=%h", i, s, a, b), q, eq);
      chk32($sformatf("rnd%0d_rem s=%0d a=%h b=%h", i, s, a, b), r, er);
      chkint($sformatf("rnd%0d_lat", i), lat, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
